// File: rtl/polyeta_pkg.sv
// Shared constants and FSM encoding for the Dilithium eta-polynomial unpacker.
package polyeta_pkg;
  localparam int N          = 256;
  localparam int ETA2       = 2;
  localparam int ETA4       = 4;
  localparam int BITS_ETA2  = 3;
  localparam int BITS_ETA4  = 4;
  localparam int BYTES_ETA2 = 96;
  localparam int BYTES_ETA4 = 128;
  localparam int COEFF_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/polyeta_lane_decode.sv
// One coefficient lane: coeff = ETA - t, as a 32-bit two's-complement value.
module polyeta_lane_decode
  import polyeta_pkg::*;
(
  input  logic [3:0]         t,
  input  logic               eta4,
  output logic [COEFF_W-1:0] coeff
);
  assign coeff = (eta4 ? COEFF_W'(ETA4) : COEFF_W'(ETA2)) - COEFF_W'(t);
endmodule

// File: rtl/polyeta_unpack_stream.sv
// Streaming eta-polynomial unpacker: IN_W-bit packed beats in, LANES signed coefficients out.
// Define POLYETA_RANGE_CHECK_EN to add the sticky err output for out-of-range t values.
module polyeta_unpack_stream
  import polyeta_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    eta4,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COEFF_W*LANES-1:0] out_coeffs,
  output logic [7:0]              out_index,
  output logic                    out_last
`ifdef POLYETA_RANGE_CHECK_EN
  ,
  output logic                    err
`endif
);
  localparam int BUF_W = IN_W + BITS_ETA4 * LANES;
  localparam int FW    = $clog2(BUF_W + 1);
  localparam int BLW   = $clog2(BYTES_ETA4 * 8 / IN_W + 1);

  state_t                         state_q, state_n;
  logic                           eta4_q;
  logic [BUF_W-1:0]               buf_q, buf_n, buf_sh;
  logic [FW-1:0]                  fill_q, fill_n, base, drain;
  logic [BLW-1:0]                 beats_left_q;
  logic [7:0]                     idx_q;
  logic                           run, in_fire, out_fire, start_ok;
  logic [LANES-1:0][3:0]          lane_t;
  logic [LANES-1:0][COEFF_W-1:0]  lane_coeff;

  assign run      = (state_q == RUN);
  assign start_ok = (state_q == IDLE) && start;
  assign drain    = eta4_q ? FW'(BITS_ETA4 * LANES) : FW'(BITS_ETA2 * LANES);

  // Ready depends only on registered state: room for a whole beat behind current fill.
  assign in_ready  = run && (beats_left_q != '0) && (fill_q <= FW'(BUF_W - IN_W));
  assign out_valid = run && (fill_q >= drain);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign busy       = run;
  assign done       = (state_q == DONE);
  assign out_index  = idx_q;
  assign out_last   = out_valid && (idx_q == 8'(N - LANES));
  assign out_coeffs = out_valid ? lane_coeff : '0;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_t[j] = eta4_q ? buf_q[BITS_ETA4*j +: BITS_ETA4]
                              : {1'b0, buf_q[BITS_ETA2*j +: BITS_ETA2]};
    polyeta_lane_decode u_dec (
      .t     (lane_t[j]),
      .eta4  (eta4_q),
      .coeff (lane_coeff[j])
    );
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (out_fire && out_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bits above fill are always zero, so a new beat can simply be OR-ed in at the new base.
  always_comb begin
    buf_sh = buf_q;
    base   = fill_q;
    if (out_fire) begin
      buf_sh = buf_q >> drain;
      base   = fill_q - drain;
    end
    buf_n  = buf_sh;
    fill_n = base;
    if (in_fire) begin
      buf_n  = buf_sh | (BUF_W'(in_data) << base);
      fill_n = base + FW'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      eta4_q       <= 1'b0;
      buf_q        <= '0;
      fill_q       <= '0;
      beats_left_q <= '0;
      idx_q        <= '0;
    end else begin
      state_q <= state_n;
      if (start_ok) begin
        eta4_q       <= eta4;
        beats_left_q <= eta4 ? BLW'(BYTES_ETA4 * 8 / IN_W) : BLW'(BYTES_ETA2 * 8 / IN_W);
        buf_q        <= '0;
        fill_q       <= '0;
        idx_q        <= '0;
      end else begin
        buf_q  <= buf_n;
        fill_q <= fill_n;
        if (in_fire)  beats_left_q <= beats_left_q - 1'b1;
        if (out_fire) idx_q <= idx_q + 8'(LANES);
      end
    end
  end

`ifdef POLYETA_RANGE_CHECK_EN
  logic [LANES-1:0] lane_bad;
  logic             err_q;

  for (genvar j = 0; j < LANES; j++) begin : g_chk
    assign lane_bad[j] = lane_t[j] > (eta4_q ? 4'd8 : 4'd4);
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_q <= 1'b0;
    else if (start_ok)               err_q <= 1'b0;
    else if (out_fire && |lane_bad)  err_q <= 1'b1;
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_polyeta_unpack_stream.sv
// Scoreboard bench for polyeta_unpack_stream: golden coefficients queued per polynomial, popped on output handshakes.
module tb_polyeta_unpack_stream;
  localparam int IN_W  = 64;
  localparam int LANES = 4;
  localparam int OW    = 32 * LANES;
  localparam int BPB   = IN_W / 8;
  localparam int PAT_ZERO = 0, PAT_RAND = 1, PAT_3A = 2, PAT_05 = 3;

  logic            clk = 1'b0;
  logic            rst, start, eta4, busy, done;
  logic            in_valid, in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid, out_ready;
  logic [OW-1:0]   out_coeffs;
  logic [7:0]      out_index;
  logic            out_last;
`ifdef POLYETA_RANGE_CHECK_EN
  logic            err;
`endif

  polyeta_unpack_stream #(.IN_W(IN_W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .eta4       (eta4),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coeffs (out_coeffs),
    .out_index  (out_index),
    .out_last   (out_last)
`ifdef POLYETA_RANGE_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] coeffs;
    logic [7:0]    idx;
    logic          last;
    logic          bad;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] bytes_m [128];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: pack random/fixed bytes, derive every coefficient as ETA - t.
  task automatic build(input bit e4, input int pat);
    int    bw;
    int    eta;
    beat_t bt;
    bw  = e4 ? 4 : 3;
    eta = e4 ? 4 : 2;
    for (int i = 0; i < 128; i++)
      bytes_m[i] = (pat == PAT_ZERO) ? 8'h00 : 8'($urandom_range(0, 255));
    if (pat == PAT_3A) bytes_m[0] = 8'h3A;
    if (pat == PAT_05) bytes_m[0] = 8'h05;
    bt.coeffs = '0;
    bt.bad    = 1'b0;
    bt.idx    = '0;
    bt.last   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      int t;
      t = 0;
      for (int b = 0; b < bw; b++) begin
        int k;
        k = bw * i + b;
        t = t | (int'(bytes_m[k / 8][k % 8]) << b);
      end
      bt.coeffs[32*(i%LANES) +: 32] = 32'(eta - t);
      if (t > 2 * eta) bt.bad = 1'b1;
      if (i % LANES == LANES - 1) begin
        bt.idx  = 8'(i - (LANES - 1));
        bt.last = (i == 255);
        exp_q.push_back(bt);
        bt.coeffs = '0;
        bt.bad    = 1'b0;
      end
    end
  endtask

  task automatic drive_beat(input int beat, input int nbeats, input int vmode);
    in_valid = (beat < nbeats) && (vmode == 0 || $urandom_range(0, 1) == 1);
    for (int k = 0; k < BPB; k++) in_data[8*k +: 8] = bytes_m[(beat * BPB + k) % 128];
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},      OW'(busy),       OW'(0));
    chk({tag, "_done"},      OW'(done),       OW'(0));
    chk({tag, "_in_ready"},  OW'(in_ready),   OW'(0));
    chk({tag, "_out_valid"}, OW'(out_valid),  OW'(0));
    chk({tag, "_coeffs"},    out_coeffs,      OW'(0));
    chk({tag, "_index"},     OW'(out_index),  OW'(0));
    chk({tag, "_last"},      OW'(out_last),   OW'(0));
`ifdef POLYETA_RANGE_CHECK_EN
    chk({tag, "_err"},       OW'(err),        OW'(0));
`endif
  endtask

  // rmode: 0 always ready, 1 toggle, 2 random. vmode: 0 always valid, 1 random.
  task automatic run_poly(input bit e4, input int pat, input int rmode, input int vmode,
                          input int abort_idx, input int poke);
    int    nbeats, beat, cyc;
    bit    first_seen, chk_lat, prev_stall, in_f, out_f, pend_bad, finished;
    beat_t held, b;
    nbeats = (e4 ? 1024 : 768) / IN_W;
    beat = 0; cyc = 0;
    first_seen = 0; chk_lat = 0; prev_stall = 0; finished = 0; pend_bad = 0;
    held.coeffs = '0; held.idx = '0; held.last = 1'b0; held.bad = 1'b0;
    exp_q.delete();
    build(e4, pat);
    @(posedge clk); #1;
    start = 1'b1; eta4 = e4; exp_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    eta4  = 1'($urandom_range(0, 1));
    drive_beat(beat, nbeats, vmode);
    out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
`ifdef POLYETA_RANGE_CHECK_EN
      chk("err", OW'(err), OW'(exp_err));
`endif
      if (cyc == 1) chk("busy_after_start", OW'(busy), OW'(1));
      if (chk_lat) begin
        chk("first_valid_latency", OW'(out_valid), OW'(1));
        chk_lat = 0;
      end
      if (abort_idx >= 0 && out_valid && out_index == 8'(abort_idx)) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_rst");
        exp_q.delete();
        return;
      end
      if (prev_stall) begin
        chk("stall_coeffs", out_coeffs, held.coeffs);
        chk("stall_index",  OW'(out_index), OW'(held.idx));
        chk("stall_last",   OW'(out_last),  OW'(held.last));
      end
      if (beat >= nbeats && in_ready) chk("ready_after_last", OW'(in_ready), OW'(0));
      in_f = in_valid && in_ready;
      out_f = out_valid && out_ready;
      pend_bad = 0;
      if (out_f) begin
        if (exp_q.size() == 0) chk("extra_beat", OW'(1), OW'(0));
        else begin
          b = exp_q.pop_front();
          chk("coeffs", out_coeffs, b.coeffs);
          chk("index",  OW'(out_index), OW'(b.idx));
          chk("last",   OW'(out_last),  OW'(b.last));
          pend_bad = b.bad;
        end
      end
      if (done) begin
        chk("busy_at_done", OW'(busy), OW'(0));
        finished = 1;
      end
      prev_stall  = out_valid && !out_ready;
      held.coeffs = out_coeffs;
      held.idx    = out_index;
      held.last   = out_last;
      if (!finished) begin
        @(posedge clk); #1;
        if (pend_bad) exp_err = 1'b1;
        if (in_f) begin
          beat++;
          if (!first_seen) begin first_seen = 1; chk_lat = 1; end
        end
        drive_beat(beat, nbeats, vmode);
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = !out_ready;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        start = (cyc == poke);
        if (cyc == poke) eta4 = !e4;
      end
    end
    if (!finished) chk("timeout_waiting_done", OW'(0), OW'(1));
    chk("in_beats", OW'(beat), OW'(nbeats));
    chk("queue_empty", OW'(exp_q.size()), OW'(0));
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", OW'(done), OW'(0));
    chk("idle_busy", OW'(busy), OW'(0));
    chk("idle_out_valid", OW'(out_valid), OW'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eta4 = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    run_poly(1'b1, PAT_3A,   0, 0, -1, -1);
    run_poly(1'b0, PAT_ZERO, 0, 0, -1, -1);
    run_poly(1'b0, PAT_05,   0, 0, -1, -1);
    run_poly(1'b0, PAT_RAND, 1, 1, -1, -1);
    run_poly(1'b1, PAT_RAND, 2, 1, -1, -1);
    run_poly(1'b1, PAT_RAND, 2, 1, 128, -1);
    run_poly(1'b1, PAT_RAND, 0, 1, -1, -1);
    run_poly(1'b0, PAT_RAND, 1, 1, -1, 8);
    run_poly(1'b1, PAT_RAND, 2, 0, -1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
